id_stage: RTL and testbench

Parametrised, pipelined successor to the single-register instruction decoder. It accepts 32-bit instructions from fetch over a valid/ready handshake and decodes them combinationally into a registered bundle, with XLEN-wide immediate extension and illegal-opcode flagging. A 2-entry skid buffer carries the bundle to execute, and a HALT interlock stops acceptance once a HALT is taken. It sits between fetch and register-read/execute in the SCC.

---
 rtl/id_pkg.sv | 51 +++++
 rtl/id_decode_comb.sv | 103 ++++++++++
 rtl/id_stage.sv | 120 ++++++++++++
 tb/tb_id_stage.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_pkg.sv
// Shared encodings and the decoded-instruction bundle for the ID stage.
// The immediate is kept outside the struct so that its width can follow XLEN.
package id_pkg;

  localparam logic [1:0] CLS_DIMM = 2'b00;
  localparam logic [1:0] CLS_DREG = 2'b01;
  localparam logic [1:0] CLS_MEM  = 2'b10;
  localparam logic [1:0] CLS_SYS  = 2'b11;

  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;
  localparam logic [2:0] ALU_OR  = 3'b100;
  localparam logic [2:0] ALU_XOR = 3'b101;
  localparam logic [2:0] ALU_NOT = 3'b110;

  localparam logic [4:0] DOP_MOV  = 5'b00000;
  localparam logic [4:0] DOP_MOVT = 5'b00001;
  localparam logic [4:0] DOP_LSR  = 5'b00101;
  localparam logic [4:0] DOP_NOT  = 5'b10110;

  localparam logic [3:0] SYS_B     = 4'b0000;
  localparam logic [3:0] SYS_BCOND = 4'b0001;
  localparam logic [3:0] SYS_BR    = 4'b0010;

  typedef enum logic [1:0] {IMM_NONE, IMM_ZEXT, IMM_SEXT, IMM_HIGH} imm_mode_e;

  typedef struct packed {
    logic [1:0] op_class;
    logic [2:0] alu_oc;
    logic       set_flags;
    logic [2:0] rd;
    logic [2:0] rs1;
    logic [2:0] rs2;
    logic [3:0] b_cond;
    logic       writes_rd;
    logic       uses_rs1;
    logic       uses_rs2;
    logic       is_load;
    logic       is_store;
    logic       is_branch;
    logic       is_halt;
    logic       illegal;
  } bundle_t;

  // Key form 1S001..1S101: the ALU ops shared by both data classes.
  function automatic logic is_alu_form(input logic [4:0] key);
    return key[4] && (key[2:0] >= ALU_ADD) && (key[2:0] <= ALU_XOR);
  endfunction

endpackage

// File: rtl/id_decode_comb.sv
// Pure combinational decode of one 32-bit instruction into a bundle plus
// the XLEN-wide extended immediate.
module id_decode_comb
  import id_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output bundle_t         bundle,
  output logic [XLEN-1:0] imm_ext
);

  logic [4:0] key;
  logic [3:0] sys;
  logic       legal;
  imm_mode_e  mode;

  assign key = instr[29:25];
  assign sys = instr[28:25];

  // Control flags are only raised on legal paths, so an illegal encoding
  // carries nothing but the raw fields and the illegal bit.
  always_comb begin
    bundle          = '0;
    legal           = 1'b0;
    mode            = IMM_NONE;
    bundle.op_class = instr[31:30];
    bundle.rd       = instr[24:22];
    bundle.rs1      = instr[21:19];
    bundle.rs2      = instr[18:16];
    bundle.b_cond   = instr[24:21];
    case (instr[31:30])
      CLS_DIMM: begin
        if (is_alu_form(key)) begin
          legal            = 1'b1;
          bundle.alu_oc    = key[2:0];
          bundle.set_flags = key[3];
          bundle.writes_rd = 1'b1;
          bundle.uses_rs1  = 1'b1;
          mode = (key[2:0] == ALU_ADD || key[2:0] == ALU_SUB) ? IMM_SEXT : IMM_ZEXT;
        end else if (key <= DOP_LSR) begin
          legal            = 1'b1;
          bundle.writes_rd = 1'b1;
          bundle.uses_rs1  = (key != DOP_MOV) && (key != DOP_MOVT);
          mode = (key == DOP_MOVT) ? IMM_HIGH : IMM_ZEXT;
        end
      end
      CLS_DREG: begin
        if (is_alu_form(key)) begin
          legal            = 1'b1;
          bundle.alu_oc    = key[2:0];
          bundle.set_flags = key[3];
          bundle.writes_rd = 1'b1;
          bundle.uses_rs1  = 1'b1;
          bundle.uses_rs2  = 1'b1;
        end else if (key == DOP_NOT) begin
          legal            = 1'b1;
          bundle.alu_oc    = ALU_NOT;
          bundle.writes_rd = 1'b1;
          bundle.uses_rs1  = 1'b1;
        end
      end
      CLS_MEM: begin
        legal           = 1'b1;
        mode            = IMM_SEXT;
        bundle.uses_rs1 = 1'b1;
        if (instr[25]) begin
          bundle.rs2      = instr[24:22];
          bundle.uses_rs2 = 1'b1;
          bundle.is_store = 1'b1;
        end else begin
          bundle.writes_rd = 1'b1;
          bundle.is_load   = 1'b1;
        end
      end
      CLS_SYS: begin
        if (sys == SYS_B || sys == SYS_BCOND || sys == SYS_BR) begin
          legal            = 1'b1;
          bundle.is_branch = 1'b1;
          bundle.uses_rs1  = (sys == SYS_BR);
          mode             = IMM_SEXT;
        end else if (instr[27]) begin
          legal = 1'b1;
        end else if (instr[28]) begin
          legal          = 1'b1;
          bundle.is_halt = 1'b1;
        end
      end
    endcase
    bundle.illegal = !legal;
  end

  always_comb begin
    imm_ext = '0;
    case (mode)
      IMM_ZEXT: imm_ext[15:0]  = instr[15:0];
      IMM_SEXT: imm_ext        = {{(XLEN-16){instr[15]}}, instr[15:0]};
      IMM_HIGH: imm_ext[31:16] = instr[15:0];
      default:  imm_ext        = '0;
    endcase
  end

endmodule

// File: rtl/id_stage.sv
// Instruction decode stage: decode on entry, then a 2-entry FIFO of decoded
// bundles towards execute, with a HALT interlock that stops intake.
module id_stage
  import id_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int PC_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic            in_ready,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [1:0]      op_class,
  output logic [2:0]      alu_oc,
  output logic            set_flags,
  output logic [2:0]      rd,
  output logic [2:0]      rs1,
  output logic [2:0]      rs2,
  output logic [XLEN-1:0] imm_ext,
  output logic [3:0]      b_cond,
  output logic            writes_rd,
  output logic            uses_rs1,
  output logic            uses_rs2,
  output logic            is_load,
  output logic            is_store,
  output logic            is_branch,
  output logic            is_halt,
  output logic            illegal,
  output logic            halted
);

  bundle_t         dec_bundle;
  logic [XLEN-1:0] dec_imm;
  bundle_t         mem_bundle [2];
  logic [XLEN-1:0] mem_imm    [2];
  logic [PC_W-1:0] mem_pc     [2];
  logic            rd_ptr;
  logic            wr_ptr;
  logic [1:0]      count;
  logic            halt_pending;
  logic            push;
  logic            pop;
  bundle_t         head;

  id_decode_comb #(.XLEN(XLEN)) u_decode (
    .instr   (in_instr),
    .bundle  (dec_bundle),
    .imm_ext (dec_imm)
  );

  // Handshake: a transfer happens on any rising edge where valid && ready;
  // valid never waits on ready, and in_ready depends only on registered state.
  assign in_ready  = !rst && (count < 2'd2) && !halt_pending && !halted;
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        mem_bundle[i] <= '0;
        mem_imm[i]    <= '0;
        mem_pc[i]     <= '0;
      end
      rd_ptr       <= 1'b0;
      wr_ptr       <= 1'b0;
      count        <= 2'd0;
      halt_pending <= 1'b0;
      halted       <= 1'b0;
    end else if (flush) begin
      rd_ptr       <= 1'b0;
      wr_ptr       <= 1'b0;
      count        <= 2'd0;
      halt_pending <= 1'b0;
    end else begin
      if (push) begin
        mem_bundle[wr_ptr] <= dec_bundle;
        mem_imm[wr_ptr]    <= dec_imm;
        mem_pc[wr_ptr]     <= in_pc;
        wr_ptr             <= ~wr_ptr;
        if (dec_bundle.is_halt) halt_pending <= 1'b1;
      end
      // A HALT in the buffer blocks intake, so this never races the set above.
      if (pop) begin
        rd_ptr <= ~rd_ptr;
        if (head.is_halt) begin
          halted       <= 1'b1;
          halt_pending <= 1'b0;
        end
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head      = mem_bundle[rd_ptr];
  assign out_pc    = mem_pc[rd_ptr];
  assign imm_ext   = mem_imm[rd_ptr];
  assign op_class  = head.op_class;
  assign alu_oc    = head.alu_oc;
  assign set_flags = head.set_flags;
  assign rd        = head.rd;
  assign rs1       = head.rs1;
  assign rs2       = head.rs2;
  assign b_cond    = head.b_cond;
  assign writes_rd = head.writes_rd;
  assign uses_rs1  = head.uses_rs1;
  assign uses_rs2  = head.uses_rs2;
  assign is_load   = head.is_load;
  assign is_store  = head.is_store;
  assign is_branch = head.is_branch;
  assign is_halt   = head.is_halt;
  assign illegal   = head.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: hand-decoded expectations are queued when an
// instruction is accepted and compared when execute consumes the head entry.
module tb_id_stage;

  localparam int XLEN = 32;
  localparam int PC_W = 16;
  localparam int W    = PC_W + 2 + 3 + 1 + 9 + XLEN + 4 + 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic [31:0]     in_instr = '0;
  logic [PC_W-1:0] in_pc = '0;
  logic            in_ready;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [PC_W-1:0] out_pc;
  logic [1:0]      op_class;
  logic [2:0]      alu_oc;
  logic            set_flags;
  logic [2:0]      rd, rs1, rs2;
  logic [XLEN-1:0] imm_ext;
  logic [3:0]      b_cond;
  logic            writes_rd, uses_rs1, uses_rs2;
  logic            is_load, is_store, is_branch, is_halt, illegal;
  logic            halted;

  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  id_stage #(.XLEN(XLEN), .PC_W(PC_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .op_class(op_class), .alu_oc(alu_oc), .set_flags(set_flags),
    .rd(rd), .rs1(rs1), .rs2(rs2), .imm_ext(imm_ext), .b_cond(b_cond),
    .writes_rd(writes_rd), .uses_rs1(uses_rs1), .uses_rs2(uses_rs2),
    .is_load(is_load), .is_store(is_store), .is_branch(is_branch),
    .is_halt(is_halt), .illegal(illegal), .halted(halted)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Flag byte order: {writes_rd, uses_rs1, uses_rs2, is_load, is_store, is_branch, is_halt, illegal}
  function automatic logic [W-1:0] ex(input logic [PC_W-1:0] pc, input logic [1:0] cls,
                                      input logic [2:0] aoc, input logic sf,
                                      input logic [2:0] r_d, input logic [2:0] r_s1,
                                      input logic [2:0] r_s2, input logic [XLEN-1:0] imm,
                                      input logic [3:0] bc, input logic [7:0] fl);
    return {pc, cls, aoc, sf, r_d, r_s1, r_s2, imm, bc, fl};
  endfunction

  function automatic logic [W-1:0] obs_pack();
    return {out_pc, op_class, alu_oc, set_flags, rd, rs1, rs2, imm_ext, b_cond,
            writes_rd, uses_rs1, uses_rs2, is_load, is_store, is_branch, is_halt, illegal};
  endfunction

  task automatic check_bit(input string tag, input logic obs, input logic expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic check_vec(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Driver: offer one instruction until accepted; waits = cycles spent stalled.
  task automatic send(input logic [31:0] instr, input logic [W-1:0] expv, output int waits);
    logic done;
    done      = 1'b0;
    waits     = 0;
    in_valid  = 1'b1;
    in_instr  = instr;
    in_pc     = expv[W-1 -: PC_W];
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(expv);
        done = 1'b1;
      end else begin
        waits++;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      n_cmp++;
      assert (done) else begin
        n_err++;
        $error("FAIL send_timeout observed=not_accepted expected=accepted instr=%h", instr);
      end
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    n_cmp++;
    assert (exp_q.size() == 0) else begin
      n_err++;
      $error("FAIL drain_timeout observed=%0d pending expected=0", exp_q.size());
    end
  endtask

  // Scoreboard: compare the head bundle on every cycle it is consumed.
  always @(negedge clk) begin
    if (!rst && !flush && out_valid && out_ready) begin
      logic [W-1:0] expv;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $error("FAIL scoreboard_unexpected observed=%h expected=none", obs_pack());
      end else begin
        expv = exp_q.pop_front();
        assert (obs_pack() === expv) else begin
          n_err++;
          $error("FAIL scoreboard observed=%h expected=%h", obs_pack(), expv);
        end
      end
    end
  end

  initial begin
    int w;
    logic [W-1:0] e_adds, e_movt, e_str, e_bcond, e_ill, e_not, e_sub, e_ldr, e_mov, e_halt;

    e_adds  = ex(16'h0100, 2'd0, 3'd1, 1'b1, 3'd3, 3'd2, 3'd0, 32'hFFFF_FFFE, 4'h6, 8'b1100_0000);
    e_movt  = ex(16'h0104, 2'd0, 3'd0, 1'b0, 3'd5, 3'd0, 3'd0, 32'h1234_0000, 4'hA, 8'b1000_0000);
    e_str   = ex(16'h0108, 2'd2, 3'd0, 1'b0, 3'd1, 3'd7, 3'd1, 32'h0000_0010, 4'h3, 8'b0110_1000);
    e_bcond = ex(16'h010C, 2'd3, 3'd0, 1'b0, 3'd5, 3'd0, 3'd0, 32'hFFFF_8000, 4'hA, 8'b0000_0100);
    e_ill   = ex(16'h0110, 2'd3, 3'd0, 1'b0, 3'd0, 3'd0, 3'd0, 32'h0000_0000, 4'h0, 8'b0000_0001);
    e_not   = ex(16'h0114, 2'd1, 3'd6, 1'b0, 3'd4, 3'd3, 3'd0, 32'h0000_0000, 4'h8, 8'b1100_0000);
    e_sub   = ex(16'h0118, 2'd1, 3'd2, 1'b1, 3'd2, 3'd5, 3'd6, 32'h0000_0000, 4'h5, 8'b1110_0000);
    e_ldr   = ex(16'h011C, 2'd2, 3'd0, 1'b0, 3'd3, 3'd1, 3'd0, 32'hFFFF_8001, 4'h6, 8'b1101_0000);
    e_mov   = ex(16'h0120, 2'd0, 3'd0, 1'b0, 3'd7, 3'd0, 3'd0, 32'h0000_8000, 4'hE, 8'b1000_0000);
    e_halt  = ex(16'h0200, 2'd3, 3'd0, 1'b0, 3'd0, 3'd0, 3'd0, 32'h0000_0000, 4'h0, 8'b0000_0010);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_bit("rst_out_valid", out_valid, 1'b0);
    check_bit("rst_in_ready", in_ready, 1'b0);
    check_bit("rst_halted", halted, 1'b0);
    check_vec("rst_bundle", obs_pack(), '0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_bit("ready_after_rst", in_ready, 1'b1);
    @(posedge clk); #1;

    // Latency 1, then decode coverage at full throughput
    send(32'h32D0_FFFE, e_adds, w);
    check_bit("latency1_out_valid", out_valid, 1'b1);
    out_ready = 1'b1;
    send(32'h0340_1234, e_movt, w);
    send(32'h8278_0010, e_str, w);
    send(32'hC340_8000, e_bcond, w);
    send(32'hC600_0000, e_ill, w);
    send(32'h6D18_0000, e_not, w);
    send(32'h74AE_ABCD, e_sub, w);
    send(32'h80C8_8001, e_ldr, w);
    send(32'h01C0_8000, e_mov, w);
    check_bit("streaming_no_stall", (w == 0), 1'b1);
    wait_drain();
    @(negedge clk);
    check_bit("drained_out_valid", out_valid, 1'b0);
    @(posedge clk); #1;

    // Backpressure: two accepted, third held off until the cycle after a pop
    out_ready = 1'b0;
    send(32'h0000_0011, ex(16'h0300, 2'd0, 3'd0, 1'b0, 3'd0, 3'd0, 3'd0, 32'h11, 4'h0, 8'b1000_0000), w);
    send(32'h0000_0022, ex(16'h0304, 2'd0, 3'd0, 1'b0, 3'd0, 3'd0, 3'd0, 32'h22, 4'h0, 8'b1000_0000), w);
    in_valid = 1'b1;
    in_instr = 32'h0000_0033;
    in_pc    = 16'h0308;
    @(negedge clk);
    check_bit("full_in_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check_bit("full_hold_in_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check_bit("full_pop_cycle_in_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    send(32'h0000_0033, ex(16'h0308, 2'd0, 3'd0, 1'b0, 3'd0, 3'd0, 3'd0, 32'h33, 4'h0, 8'b1000_0000), w);
    check_bit("accept_after_pop", (w == 0), 1'b1);
    wait_drain();

    // HALT interlock
    out_ready = 1'b0;
    @(posedge clk); #1;
    send(32'hD000_0000, e_halt, w);
    @(negedge clk);
    check_bit("halt_pending_blocks", in_ready, 1'b0);
    check_bit("halted_before_dequeue", halted, 1'b0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    check_bit("halted_after_dequeue", halted, 1'b1);
    check_bit("halted_blocks", in_ready, 1'b0);
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check_bit("flush_keeps_halted", halted, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_bit("rst_clears_halted", halted, 1'b0);
    check_bit("ready_after_halt_rst", in_ready, 1'b1);
    @(posedge clk); #1;

    // Flush with two buffered entries and a concurrent offer
    send(32'h0000_0044, ex(16'h0400, 2'd0, 3'd0, 1'b0, 3'd0, 3'd0, 3'd0, 32'h44, 4'h0, 8'b1000_0000), w);
    send(32'h0000_0055, ex(16'h0404, 2'd0, 3'd0, 1'b0, 3'd0, 3'd0, 3'd0, 32'h55, 4'h0, 8'b1000_0000), w);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_instr = 32'h0000_0066;
    in_pc    = 16'h0408;
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check_bit("flush_out_valid", out_valid, 1'b0);
    check_bit("flush_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    check_bit("flush_no_capture", out_valid, 1'b0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(32'h0000_0077, ex(16'h040C, 2'd0, 3'd0, 1'b0, 3'd0, 3'd0, 3'd0, 32'h77, 4'h0, 8'b1000_0000), w);
    wait_drain();

    // Reset mid-stream
    out_ready = 1'b0;
    send(32'h32D0_FFFE, ex(16'h0500, 2'd0, 3'd1, 1'b1, 3'd3, 3'd2, 3'd0, 32'hFFFF_FFFE, 4'h6, 8'b1100_0000), w);
    send(32'hC340_8000, ex(16'h0504, 2'd3, 3'd0, 1'b0, 3'd5, 3'd0, 3'd0, 32'hFFFF_8000, 4'hA, 8'b0000_0100), w);
    rst = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    @(negedge clk);
    check_vec("midrst_bundle", obs_pack(), '0);
    check_bit("midrst_out_valid", out_valid, 1'b0);
    check_bit("midrst_in_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_bit("midrst_ready_after", in_ready, 1'b1);
    check_bit("midrst_empty_after", out_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
